seq_chunk_adder: RTL

//   Multi-cycle, parametrised add/subtract unit: processes WIDTH-bit operands CHUNK bits
//   per clock through a CHUNK-bit full-adder slice, carry held in a register between chunks.

---
 rtl/seq_chunk_adder.sv | 135 +++++++++++++
 1 files changed

// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract unit that walks WIDTH-bit operands CHUNK bits per
// clock through one CHUNK-bit adder slice. The carry is held in a register
// between chunks. A start/busy/done handshake frames each operation.
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [CHUNK-1:0] a_chunk;
  logic [CHUNK-1:0] b_chunk;
  logic [CHUNK:0]   chunk_res;
  logic             msb_carry_in;

  // Next-state logic: operand capture on accept, one adder slice per BUSY cycle,
  // and the Moore outputs precomputed from the next state so they come out of flops.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    a_chunk   = a_q[idx_q*CHUNK +: CHUNK];
    b_chunk   = b_q[idx_q*CHUNK +: CHUNK];
    chunk_res = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
    // The carry into the top bit of the slice is recovered from that bit's sum
    // and operands, which also covers the bit-serial case without a special path.
    msb_carry_in = chunk_res[CHUNK-1] ^ a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1];

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = op ? ~b : b;
          carry_d = op ? 1'b1 : cin;
          idx_d   = '0;
          sum_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        sum_d[idx_q*CHUNK +: CHUNK] = chunk_res[CHUNK-1:0];
        carry_d = chunk_res[CHUNK];
        if (idx_q == LAST_IDX) begin
          cout_d  = chunk_res[CHUNK];
          ovf_d   = msb_carry_in ^ chunk_res[CHUNK];
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == BUSY);
    done_d = (state_d == DONE);
  end

  // State and output registers; synchronous reset discards any partial result.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
